// File: rtl/fmap_writer.sv
// rtl/fmap_writer.sv - collects a stream of 1-bit conv results into an OH x OW feature map with a read port
module fmap_writer #(
    parameter int H      = 5,
    parameter int W      = 5,
    parameter int K      = 3,
    parameter int S      = 1,
    parameter int P      = 1,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_valid,
    input  logic              i_pixel,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_row,
    output logic [ADDR_W-1:0] o_col,
    output logic              o_busy,
    output logic              o_done,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              o_rpixel
);

    // Output map geometry (floor division).
    localparam int OH = (H + 2 * P - K) / S + 1;
    localparam int OW = (W + 2 * P - K) / S + 1;
    localparam int N  = OH * OW;

    // Geometry expressed in counter width so all index math stays in ADDR_W bits.
    localparam logic [ADDR_W-1:0] OW_A    = ADDR_W'(OW);
    localparam logic [ADDR_W-1:0] LAST_R  = ADDR_W'(OH - 1);
    localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(OW - 1);
    localparam logic [ADDR_W-1:0] N_A     = ADDR_W'(N);

    // The map must be fully addressable, otherwise row*OW+col would wrap.
    generate
        if (N > (2 ** ADDR_W)) begin : g_bad_addr_w
            $error("fmap_writer: OH*OW exceeds 2**ADDR_W");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [N-1:0]      mem;
    logic [ADDR_W-1:0] widx;
    logic              accept;
    logic              last_beat;

    // Linear write address of the next beat, row-major.
    assign widx      = row * OW_A + col;
    // ready depends only on state, so accept is simply valid while filling.
    assign accept    = (state == ST_FILL) && i_valid;
    assign last_beat = (row == LAST_R) && (col == LAST_C);

    // Frame state machine, position counters and map storage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            row   <= '0;
            col   <= '0;
            mem   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= ST_FILL;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        mem[widx] <= i_pixel;
                        if (last_beat) begin
                            state <= ST_DONE;
                            row   <= '0;
                            col   <= '0;
                        end else if (col == LAST_C) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // A new frame overwrites the map in place; no clear.
                    if (i_start) begin
                        state <= ST_FILL;
                        row   <= '0;
                        col   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    row   <= '0;
                    col   <= '0;
                end
            endcase
        end
    end

    // Status decoded from state only.
    assign o_ready = (state == ST_FILL);
    assign o_busy  = (state == ST_FILL);
    assign o_done  = (state == ST_DONE);
    assign o_row   = row;
    assign o_col   = col;

    // Combinational read; addresses past the map read as zero.
    always_comb begin
        o_rpixel = 1'b0;
        if (i_raddr < N_A) begin
            o_rpixel = mem[i_raddr];
        end
    end

endmodule

// File: tb/tb_fmap_writer.sv
// tb/tb_fmap_writer.sv - directed self-checking bench for fmap_writer
module tb_fmap_writer;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_valid;
    logic       i_pixel;
    logic       o_ready;
    logic [4:0] o_row;
    logic [4:0] o_col;
    logic       o_busy;
    logic       o_done;
    logic [4:0] i_raddr;
    logic       o_rpixel;

    int checks = 0;
    int errors = 0;

    fmap_writer dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_valid  (i_valid),
        .i_pixel  (i_pixel),
        .o_ready  (o_ready),
        .o_row    (o_row),
        .o_col    (o_col),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .i_raddr  (i_raddr),
        .o_rpixel (o_rpixel)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset;
        i_rst = 1'b1;
        tick();
        tick();
        checks++;
        if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: ready=%b busy=%b done=%b expected 0 0 0", o_ready, o_busy, o_done);
        end
        for (int a = 0; a < 32; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== 1'b0) begin
                errors++;
                $display("FAIL reset_mem addr=%0d: got %b expected 0", a, o_rpixel);
            end
        end
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_ignored_idle;
        i_valid = 1'b1;
        i_pixel = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        i_valid = 1'b0;
        checks++;
        if (o_ready !== 1'b0 || o_row !== 5'd0 || o_col !== 5'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_ignore: ready=%b row=%0d col=%0d busy=%b expected 0 0 0 0", o_ready, o_row, o_col, o_busy);
        end
        for (int a = 0; a < 25; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== 1'b0) begin
                errors++;
                $display("FAIL idle_mem addr=%0d: got %b expected 0", a, o_rpixel);
            end
        end
    endtask

    task automatic test_back_to_back;
        pulse_start();
        checks++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_start: busy=%b ready=%b done=%b expected 1 1 0", o_busy, o_ready, o_done);
        end
        for (int b = 0; b < 25; b++) begin
            i_valid = 1'b1;
            i_pixel = b[0];
            checks++;
            if (o_row !== 5'(b / 5) || o_col !== 5'(b % 5) || o_done !== 1'b0) begin
                errors++;
                $display("FAIL b2b_pos beat=%0d: row=%0d col=%0d done=%b expected %0d %0d 0", b, o_row, o_col, o_done, b / 5, b % 5);
            end
            tick();
        end
        i_valid = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_ready !== 1'b0 || o_busy !== 1'b0 || o_row !== 5'd0 || o_col !== 5'd0) begin
            errors++;
            $display("FAIL b2b_done: done=%b ready=%b busy=%b row=%0d col=%0d expected 1 0 0 0 0", o_done, o_ready, o_busy, o_row, o_col);
        end
        for (int a = 0; a < 25; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== a[0]) begin
                errors++;
                $display("FAIL b2b_mem addr=%0d: got %b expected %b", a, o_rpixel, a[0]);
            end
        end
    endtask

    task automatic test_gapped_valid;
        int acc;
        acc = 0;
        pulse_start();
        i_pixel = 1'b1;
        for (int c = 0; c < 49; c++) begin
            i_valid = (c % 2 == 0);
            tick();
            if (c % 2 == 0) acc++;
            checks++;
            if (o_done !== (acc == 25)) begin
                errors++;
                $display("FAIL gap_done cycle=%0d accepts=%0d: got %b expected %b", c, acc, o_done, acc == 25);
            end
        end
        i_valid = 1'b0;
        for (int a = 0; a < 25; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== 1'b1) begin
                errors++;
                $display("FAIL gap_mem addr=%0d: got %b expected 1", a, o_rpixel);
            end
        end
    endtask

    task automatic test_ignored_done;
        pulse_start();
        for (int b = 0; b < 25; b++) begin
            i_valid = 1'b1;
            i_pixel = 1'b0;
            i_start = (b == 9);
            tick();
            i_start = 1'b0;
            if (b == 10) begin
                checks++;
                if (o_row !== 5'd2 || o_col !== 5'd1 || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL start_in_fill: row=%0d col=%0d busy=%b expected 2 1 1", o_row, o_col, o_busy);
                end
            end
            if (b == 23) begin
                checks++;
                if (o_done !== 1'b0) begin
                    errors++;
                    $display("FAIL early_done: got %b expected 0", o_done);
                end
            end
        end
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL zero_frame_done: got %b expected 1", o_done);
        end
        i_pixel = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        i_valid = 1'b0;
        checks++;
        if (o_done !== 1'b1 || o_ready !== 1'b0 || o_row !== 5'd0 || o_col !== 5'd0) begin
            errors++;
            $display("FAIL done_ignore: done=%b ready=%b row=%0d col=%0d expected 1 0 0 0", o_done, o_ready, o_row, o_col);
        end
        for (int a = 0; a < 25; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== 1'b0) begin
                errors++;
                $display("FAIL done_mem addr=%0d: got %b expected 0", a, o_rpixel);
            end
        end
    endtask

    task automatic test_mid_reset;
        pulse_start();
        i_pixel = 1'b1;
        i_valid = 1'b1;
        for (int b = 0; b < 10; b++) tick();
        i_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_row !== 5'd0 || o_col !== 5'd0) begin
                errors++;
                $display("FAIL mid_reset_state cycle=%0d: ready=%b busy=%b done=%b row=%0d col=%0d expected 0 0 0 0 0", c, o_ready, o_busy, o_done, o_row, o_col);
            end
        end
        i_valid = 1'b0;
        for (int a = 0; a < 25; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset_mem addr=%0d: got %b expected 0", a, o_rpixel);
            end
        end
    endtask

    task automatic test_restart_range;
        pulse_start();
        i_valid = 1'b1;
        i_pixel = 1'b1;
        for (int b = 0; b < 25; b++) tick();
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL ones_done: got %b expected 1", o_done);
        end
        i_valid = 1'b0;
        pulse_start();
        i_valid = 1'b1;
        i_pixel = 1'b0;
        for (int b = 0; b < 3; b++) tick();
        i_valid = 1'b0;
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b1 || o_row !== 5'd0 || o_col !== 5'd3) begin
            errors++;
            $display("FAIL restart_state: done=%b busy=%b row=%0d col=%0d expected 0 1 0 3", o_done, o_busy, o_row, o_col);
        end
        for (int a = 0; a < 32; a++) begin
            i_raddr = 5'(a);
            #1;
            checks++;
            if (o_rpixel !== ((a >= 3) && (a < 25))) begin
                errors++;
                $display("FAIL restart_mem addr=%0d: got %b expected %b", a, o_rpixel, (a >= 3) && (a < 25));
            end
        end
    endtask

    initial begin
        i_rst   = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        i_pixel = 1'b0;
        i_raddr = '0;
        test_reset();
        test_ignored_idle();
        test_back_to_back();
        test_gapped_valid();
        test_ignored_done();
        test_mid_reset();
        test_restart_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
